// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned add/sub/mul/div unit with a start/busy/done handshake.
// Add, sub and divide-by-zero finish in one cycle; mul and div iterate once per bit.
module seq_arith_unit #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             op_q, op_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic [2*WIDTH:0]       acc_q, acc_d;
   logic [2*WIDTH-1:0]     result_q, result_d;
   logic                   err_q, err_d;

   logic [WIDTH:0]         add_sum;
   logic [WIDTH:0]         sub_diff;
   logic [WIDTH:0]         mul_sum;
   logic [WIDTH:0]         div_rem_sh;
   logic [WIDTH:0]         div_trial;
   logic [2*WIDTH:0]       calc_nxt;

   assign add_sum  = {1'b0, a} + {1'b0, b};
   assign sub_diff = {1'b0, a} - {1'b0, b};

   // Mul: acc = {upper half (WIDTH+1 bits), multiplier}; the spare top bit keeps the carry.
   assign mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

   // Div: acc[2W-1:W] holds the partial remainder, acc[W-1:0] the dividend/quotient.
   assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_trial  = div_rem_sh - {1'b0, b_q};

   always_comb begin
      calc_nxt = acc_q;
      if (op_q == OP_MUL) begin
         calc_nxt = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
      end else if (div_trial[WIDTH]) begin
         calc_nxt = {1'b0, div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         calc_nxt = {1'b0, div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = op;
               b_d   = b;
               cnt_d = '0;
               case (op)
                  OP_ADD: begin
                     result_d = (2*WIDTH)'(add_sum);
                     err_d    = 1'b0;
                     state_d  = S_DONE;
                  end
                  OP_SUB: begin
                     result_d = (2*WIDTH)'(sub_diff);
                     err_d    = 1'b0;
                     state_d  = S_DONE;
                  end
                  OP_MUL: begin
                     acc_d   = {{(WIDTH+1){1'b0}}, a};
                     state_d = S_CALC;
                  end
                  default: begin
                     if (b == '0) begin
                        result_d = {a, {WIDTH{1'b1}}};
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                     end else begin
                        acc_d   = {{(WIDTH+1){1'b0}}, a};
                        state_d = S_CALC;
                     end
                  end
               endcase
            end
         end

         S_CALC: begin
            acc_d = calc_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = calc_nxt[2*WIDTH-1:0];
               err_d    = 1'b0;
               cnt_d    = '0;
               state_d  = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_ADD;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit at WIDTH=4 and WIDTH=8.
module tb_seq_arith_unit;

   typedef struct {
      logic [15:0] res;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        start4 = 1'b0, start8 = 1'b0;
   logic [1:0]  op4 = 2'b00, op8 = 2'b00;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy4, done4, err4, busy8, done8, err8;
   logic [7:0]  result4;
   logic [15:0] result8;

   exp_t q4[$];
   exp_t q8[$];
   exp_t e4, e8;

   seq_arith_unit #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .err(err4), .result(result4)
   );

   seq_arith_unit #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .err(err8), .result(result8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (done4) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done4: got done with empty scoreboard, expected none (cycle %0d)", cyc);
         end else begin
            e4 = q4.pop_front();
            chk("res4", 32'({8'h00, result4}), 32'(e4.res));
            chk("err4", 32'(err4), 32'(e4.err));
            chk("lat4", 32'(cyc - e4.acc + 1), 32'(e4.lat));
         end
      end
      if (done8) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done8: got done with empty scoreboard, expected none (cycle %0d)", cyc);
         end else begin
            e8 = q8.pop_front();
            chk("res8", 32'(result8), 32'(e8.res));
            chk("err8", 32'(err8), 32'(e8.err));
            chk("lat8", 32'(cyc - e8.acc + 1), 32'(e8.lat));
         end
      end
   end

   task automatic wait_idle4();
      int t = 0;
      @(negedge clk);
      while (busy4 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy4) chk("idle4_timeout", 32'(busy4), 32'(0));
   endtask

   task automatic wait_idle8();
      int t = 0;
      @(negedge clk);
      while (busy8 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy8) chk("idle8_timeout", 32'(busy8), 32'(0));
   endtask

   task automatic drive4(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                         input logic [15:0] er, input logic ee, input int el);
      wait_idle4();
      start4 = 1'b1; op4 = o; a4 = x; b4 = y;
      @(posedge clk);
      #1;
      q4.push_back('{er, ee, el, cyc});
      start4 = 1'b0;
   endtask

   task automatic drive8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] er, input logic ee, input int el);
      wait_idle8();
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(posedge clk);
      #1;
      q8.push_back('{er, ee, el, cyc});
      start8 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  ro;
      logic [7:0]  rx, ry;
      logic [15:0] rres;
      logic        rerr;
      int          rlat;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy4", 32'(busy4), 32'(0));
      chk("rst_done4", 32'(done4), 32'(0));
      chk("rst_err4", 32'(err4), 32'(0));
      chk("rst_result4", 32'(result4), 32'(0));
      chk("rst_busy8", 32'(busy8), 32'(0));
      chk("rst_result8", 32'(result8), 32'(0));
      rst = 1'b0;

      // Add: one-cycle latency, busy for exactly one cycle.
      drive4(2'b00, 4'd12, 4'd5, 16'h0011, 1'b0, 1);
      @(negedge clk);
      chk("add_busy_c1", 32'(busy4), 32'(1));
      @(negedge clk);
      chk("add_busy_c2", 32'(busy4), 32'(0));

      drive4(2'b01, 4'd3, 4'd3, 16'h0000, 1'b0, 1);
      drive4(2'b01, 4'd0, 4'd1, 16'h001F, 1'b0, 1);

      // Mul with a stray start during CALC that must be ignored.
      drive4(2'b10, 4'd15, 4'd15, 16'h00E1, 1'b0, 5);
      @(negedge clk);
      @(negedge clk);
      start4 = 1'b1; op4 = 2'b00; a4 = 4'd1; b4 = 4'd1;
      @(negedge clk);
      start4 = 1'b0;
      wait_idle4();
      repeat (3) @(negedge clk);
      chk("mul_hold", 32'(result4), 32'(8'hE1));

      drive4(2'b11, 4'd12, 4'd5, 16'h0022, 1'b0, 5);
      drive4(2'b11, 4'd7, 4'd0, 16'h007F, 1'b1, 1);

      // Result is not cleared when a new operation is accepted.
      drive4(2'b10, 4'd15, 4'd15, 16'h00E1, 1'b0, 5);
      @(negedge clk);
      chk("hold_on_start", 32'(result4), 32'(8'h7F));
      chk("hold_err_on_start", 32'(err4), 32'(1));
      wait_idle4();

      // Async reset two cycles into a mul.
      drive4(2'b10, 4'd15, 4'd15, 16'h00E1, 1'b0, 5);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy4", 32'(busy4), 32'(0));
      chk("arst_done4", 32'(done4), 32'(0));
      chk("arst_err4", 32'(err4), 32'(0));
      chk("arst_result4", 32'(result4), 32'(0));
      q4.delete();
      @(negedge clk);
      rst = 1'b0;
      drive4(2'b00, 4'd1, 4'd1, 16'h0002, 1'b0, 1);

      // WIDTH=8 directed.
      drive8(2'b10, 8'd200, 8'd100, 16'h4E20, 1'b0, 9);
      drive8(2'b11, 8'd255, 8'd16, 16'h0F0F, 1'b0, 9);

      // WIDTH=8 random against a behavioural model.
      for (int i = 0; i < 1000; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = 8'($urandom_range(0, 255));
         ry = (i % 40 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         rerr = 1'b0;
         rlat = 1;
         case (ro)
            2'b00: rres = 16'(rx) + 16'(ry);
            2'b01: rres = ((rx < ry) ? 16'h0100 : 16'h0000) | 16'(8'(rx - ry));
            2'b10: begin
               rres = 16'(rx) * 16'(ry);
               rlat = 9;
            end
            default: begin
               if (ry == 8'd0) begin
                  rres = {rx, 8'hFF};
                  rerr = 1'b1;
               end else begin
                  rres = {8'(rx % ry), 8'(rx / ry)};
                  rlat = 9;
               end
            end
         endcase
         drive8(ro, rx, ry, rres, rerr, rlat);
      end

      wait_idle4();
      wait_idle8();
      repeat (3) @(negedge clk);
      chk("q4_drained", 32'(q4.size()), 32'(0));
      chk("q8_drained", 32'(q8.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised, multi-cycle arithmetic unit; successor to the 4-bit combinational add/sub/mul/div block.
- One operation per request over a start/busy/done handshake. Add and sub complete in one cycle; mul uses a shift-add loop and div a restoring-division loop.
- Sits between operator-practice datapaths and any sequential controller that needs arithmetic without a combinational multiplier or divider.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result is valid when it rises.
- err  output  1  divide-by-zero flag; valid with done.
- result  output  2*WIDTH  packed result (format below).

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, err=0, result=0, counter=0. Internal a/b/accumulator registers are cleared. No partial result survives reset.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 captures a, b, op.
    - op add, op sub, or div with b==0: next state DONE.
    - mul, or div with b!=0: next state CALC, counter=0.
  - CALC: one iteration per cycle. After WIDTH iterations (counter==WIDTH-1 at the edge), next state DONE.
  - DONE: done=1 for exactly this cycle; next state IDLE.
- busy=1 in CALC and DONE. start is ignored whenever busy=1; captured operands are not disturbed.
- Latency, from the edge that accepts start to the first cycle with done=1:
  - add and sub: 1 cycle.
  - div by zero: 1 cycle.
  - mul and div: WIDTH+1 cycles.
  - Minimum spacing between accepted starts is 2 cycles for add/sub and WIDTH+2 cycles for mul/div.
- result updates only on the transition into DONE. It holds until the next accepted operation completes; it is not cleared on start.
- result format (unused upper bits are 0):
  - add: result[WIDTH:0] = a+b, including the carry.
  - sub: result[WIDTH-1:0] = (a-b) mod 2^WIDTH; result[WIDTH] = borrow (1 when a<b).
  - mul: result = a*b, full 2*WIDTH bits, unsigned.
  - div: result = {rem, quot}, each WIDTH bits, unsigned.
- mul algorithm: per iteration, test the multiplier LSB, conditionally add the multiplicand into the upper half, then shift right one bit. Accumulator is 2*WIDTH+1 bits so the carry is not lost.
- div algorithm: restoring. Per iteration, shift {rem, quot} left by one, trial-subtract b from rem (WIDTH+1-bit subtract), and keep the subtraction when there is no borrow, setting quot LSB=1.
- div by zero: err=1, quot = all ones, rem = a. No CALC cycles.
- err=0 for every other completed operation. err is updated at the same edge as result.
- op values are fully decoded; there is no illegal encoding.
- All arithmetic is unsigned; no signed mode.

Test Plan:
- WIDTH=4, add a=12 b=5 -> done exactly 1 cycle after accept, result=0x11 (17), err=0, busy high for 1 cycle.
- WIDTH=4, sub a=3 b=3 -> result=0x00. Then sub a=0 b=1 -> result=0x1F (diff=0xF, borrow=1).
- WIDTH=4, mul a=15 b=15 -> done 5 cycles after accept, result=0xE1 (225). A start pulsed with op=add during CALC is ignored: result is still 225 and no extra done.
- WIDTH=4, div a=12 b=5 -> result=0x22 (rem=2, quot=2) after 5 cycles. Div a=7 b=0 -> done after 1 cycle, err=1, result=0x7F.
- WIDTH=4, assert rst 2 cycles into a mul -> busy, done, err and result go to 0 immediately, without waiting for a clock edge. After release, add 1+1 -> result=0x02 with normal 1-cycle latency.
- WIDTH=8 regression:
  - mul 200*100 -> result=0x4E20 after 9 cycles.
  - div 255/16 -> quot=15, rem=15, result=0x0F0F.
  - 1000 random operands and ops checked against a behavioural model.
